// File: rtl/game_tick_gen.sv
// Round pacer: latches the player's level, then emits periodic game ticks and a round-complete pulse.
// Latency: first tick is registered PRESCALE*P edges after the edge that accepts start.
// Backpressure: pause freezes all counts in place; no tick is lost or repeated across a pause.
module game_tick_gen #(
   parameter int unsigned PRESCALE      = 50000,
   parameter int unsigned PERIOD_NORMAL = 500,
   parameter int unsigned PERIOD_INTER  = 300,
   parameter int unsigned PERIOD_ADV    = 150,
   parameter int unsigned ROUND_TICKS   = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic       userLog,
   input  logic       start,
   input  logic       pause,
   output logic       tick,
   output logic       round_done,
   output logic       round_active,
   output logic [7:0] ticks_left,
   output logic [1:0] level
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      RUN    = 3'd2,
      PAUSED = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [15:0] PSC_LAST    = 16'(PRESCALE - 1);
   localparam logic [9:0]  NORMAL_LAST = 10'(PERIOD_NORMAL - 1);
   localparam logic [9:0]  INTER_LAST  = 10'(PERIOD_INTER - 1);
   localparam logic [9:0]  ADV_LAST    = 10'(PERIOD_ADV - 1);
   localparam logic [7:0]  ROUND_LOAD  = 8'(ROUND_TICKS);

   state_t      state_q, state_d;
   logic [15:0] psc_q, psc_d;
   logic [9:0]  step_q, step_d;
   logic [7:0]  ticks_left_q, ticks_left_d;
   logic [1:0]  level_q, level_d;
   logic        tick_q, tick_d;
   logic        round_done_q, round_done_d;
   logic        round_active_q, round_active_d;
   logic [9:0]  step_last;

   // Last step-counter value for the latched level; code 11 never latches but falls back to normal
   always_comb begin
      step_last = NORMAL_LAST;
      case (level_q)
         2'b01:   step_last = INTER_LAST;
         2'b10:   step_last = ADV_LAST;
         default: step_last = NORMAL_LAST;
      endcase
   end

   // Next-state logic: userLog drop outranks pause, pause outranks counting/ticking
   always_comb begin
      state_d        = state_q;
      psc_d          = psc_q;
      step_d         = step_q;
      ticks_left_d   = ticks_left_q;
      level_d        = level_q;
      tick_d         = 1'b0;
      round_done_d   = 1'b0;
      round_active_d = round_active_q;

      if (state_q != IDLE && !userLog) begin
         // Losing the verified user aborts everything except the latched level
         state_d        = IDLE;
         psc_d          = '0;
         step_d         = '0;
         ticks_left_d   = '0;
         round_active_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (userLog) begin
                  level_d = (speed == 2'b11) ? 2'b00 : speed;
                  state_d = ARMED;
               end
            end
            ARMED, DONE: begin
               if (start) begin
                  psc_d          = '0;
                  step_d         = '0;
                  ticks_left_d   = ROUND_LOAD;
                  round_active_d = 1'b1;
                  state_d        = RUN;
               end
            end
            RUN, PAUSED: begin
               if (pause) begin
                  // Counts hold; a tick due on this edge is deferred, not dropped
                  state_d = PAUSED;
               end else begin
                  // Releasing pause counts on the same edge, so the delay equals the paused edges
                  state_d = RUN;
                  if (psc_q == PSC_LAST) begin
                     psc_d = '0;
                     if (step_q == step_last) begin
                        step_d       = '0;
                        tick_d       = 1'b1;
                        ticks_left_d = ticks_left_q - 8'd1;
                        if (ticks_left_q == 8'd1) begin
                           round_done_d   = 1'b1;
                           round_active_d = 1'b0;
                           state_d        = DONE;
                        end
                     end else begin
                        step_d = step_q + 10'd1;
                     end
                  end else begin
                     psc_d = psc_q + 16'd1;
                  end
               end
            end
            default: begin
               state_d        = IDLE;
               psc_d          = '0;
               step_d         = '0;
               ticks_left_d   = '0;
               round_active_d = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; synchronous active-low reset wins over everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         psc_q          <= '0;
         step_q         <= '0;
         ticks_left_q   <= '0;
         level_q        <= 2'b00;
         tick_q         <= 1'b0;
         round_done_q   <= 1'b0;
         round_active_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         psc_q          <= psc_d;
         step_q         <= step_d;
         ticks_left_q   <= ticks_left_d;
         level_q        <= level_d;
         tick_q         <= tick_d;
         round_done_q   <= round_done_d;
         round_active_q <= round_active_d;
      end
   end

   assign tick         = tick_q;
   assign round_done   = round_done_q;
   assign round_active = round_active_q;
   assign ticks_left   = ticks_left_q;
   assign level        = level_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen: directed scenarios followed by randomized traffic,
// every cycle compared against an elapsed-time reference model.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_game_tick_gen;

   localparam int PRESCALE = 4;
   localparam int P_NORMAL = 5;
   localparam int P_INTER  = 3;
   localparam int P_ADV    = 2;
   localparam int RT       = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] speed = 2'b00;
   logic       userLog = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       tick;
   logic       round_done;
   logic       round_active;
   logic [7:0] ticks_left;
   logic [1:0] level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_tick = -1;
   int exp_gap = 0;

   // Reference model: a verified flag, an in-round flag and elapsed active edges
   bit   m_ver = 0;
   bit   m_run = 0;
   bit   m_tick = 0;
   bit   m_done = 0;
   int   m_el = 0;
   int   m_tl = 0;
   int   m_lvl = 0;

   game_tick_gen #(
      .PRESCALE(PRESCALE),
      .PERIOD_NORMAL(P_NORMAL),
      .PERIOD_INTER(P_INTER),
      .PERIOD_ADV(P_ADV),
      .ROUND_TICKS(RT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .speed(speed),
      .userLog(userLog),
      .start(start),
      .pause(pause),
      .tick(tick),
      .round_done(round_done),
      .round_active(round_active),
      .ticks_left(ticks_left),
      .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int edges_per_tick(input int lvl);
      case (lvl)
         1:       return PRESCALE * P_INTER;
         2:       return PRESCALE * P_ADV;
         default: return PRESCALE * P_NORMAL;
      endcase
   endfunction

   task automatic model_step();
      m_tick = 0;
      m_done = 0;
      if (!rst) begin
         m_ver = 0; m_run = 0; m_el = 0; m_tl = 0; m_lvl = 0;
      end else if (!m_ver) begin
         if (userLog) begin
            m_ver = 1;
            m_lvl = (speed == 2'b11) ? 0 : int'(speed);
         end
      end else if (!userLog) begin
         m_ver = 0; m_run = 0; m_el = 0; m_tl = 0;
      end else if (m_run) begin
         if (!pause) begin
            m_el++;
            if (m_el % edges_per_tick(m_lvl) == 0) begin
               m_tick = 1;
               m_tl--;
               if (m_tl == 0) begin
                  m_done = 1;
                  m_run = 0;
               end
            end
         end
      end else if (start) begin
         m_run = 1; m_el = 0; m_tl = RT;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("tick", tick, m_tick);
      chk("round_done", round_done, m_done);
      chk("round_active", round_active, m_run);
      chk("ticks_left", ticks_left, m_tl);
      chk("level", level, m_lvl);
      if (tick && exp_gap != 0) begin
         if (last_tick >= 0) chk("tick_gap", cyc - last_tick, exp_gap);
         last_tick = cyc;
      end
   endtask

   task automatic begin_round(input int gap);
      start = 1'b1;
      last_tick = -1;
      exp_gap = gap;
      cycle();
      start = 1'b0;
   endtask

   task automatic relatch(input logic [1:0] spd);
      userLog = 1'b0;
      cycle();
      speed = spd;
      userLog = 1'b1;
      cycle();
   endtask

   initial begin
      // Reset, then start pulses with no verified user
      repeat (2) cycle();
      chk("rst_tick", tick, 0);
      chk("rst_active", round_active, 0);
      chk("rst_ticks_left", ticks_left, 0);
      chk("rst_level", level, 0);
      rst = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
      chk("idle_no_round", round_active, 0);

      // Advanced level: ticks 8 cycles apart, round of three
      speed = 2'b10;
      userLog = 1'b1;
      cycle();
      chk("lvl_adv", level, 2);
      begin_round(PRESCALE * P_ADV);
      chk("adv_active", round_active, 1);
      chk("adv_ticks_left", ticks_left, 3);
      repeat (26) cycle();
      chk("adv_done_inactive", round_active, 0);

      // Code 11 latches as normal; start mid-round ignored; start in DONE restarts
      relatch(2'b11);
      chk("lvl_11", level, 0);
      begin_round(PRESCALE * P_NORMAL);
      repeat (30) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (40) cycle();
      chk("normal_done_inactive", round_active, 0);
      begin_round(PRESCALE * P_NORMAL);
      chk("restart_ticks_left", ticks_left, 3);
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (i == 20) chk("restart_first_tick", tick, 1);
      end
      exp_gap = 0;

      // Pause: 7 cycles starting 2 before a due tick, then pause exactly on a due tick
      relatch(2'b01);
      begin_round(0);
      for (int i = 0; i < 100 && m_el != 10; i++) cycle();
      pause = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("pause_no_tick", tick, 0);
         chk("pause_ticks_held", ticks_left, 3);
      end
      pause = 1'b0;
      cycle();
      cycle();
      chk("delayed_tick", tick, 1);
      for (int i = 0; i < 100 && m_el != 23; i++) cycle();
      pause = 1'b1;
      cycle();
      chk("pause_due_no_tick", tick, 0);
      pause = 1'b0;
      cycle();
      chk("resume_tick", tick, 1);

      // userLog dropped while paused
      pause = 1'b1;
      cycle();
      userLog = 1'b0;
      cycle();
      chk("drop_inactive", round_active, 0);
      chk("drop_level_held", level, 1);
      pause = 1'b0;

      // Reset mid-round
      speed = 2'b10;
      userLog = 1'b1;
      cycle();
      begin_round(0);
      repeat (5) cycle();
      rst = 1'b0;
      cycle();
      chk("midrst_active", round_active, 0);
      chk("midrst_ticks_left", ticks_left, 0);
      chk("midrst_level", level, 0);
      rst = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst     = ($urandom_range(0, 499) != 0);
         userLog = ($urandom_range(0, 149) != 0);
         speed   = 2'($urandom_range(0, 3));
         start   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 14) == 0) pause = ~pause;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
